// File: rtl/program_loader.sv
// Instruction-memory program loader: streams host words into memory from address 0,
// optionally reads the image back against a running checksum, then releases the core.
module program_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter bit          VERIFY = 1'b1
) (
    input  logic              clk_i,
    input  logic              clr_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              halt_i,
    input  logic              host_valid_i,
    input  logic [DATA_W-1:0] host_data_i,
    output logic              host_ready_o,
    output logic              mem_en_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              cpu_clr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [DATA_W-1:0] load_csum_o
);

    typedef enum logic [2:0] {StIdle, StLoad, StVerify, StRun, StError} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] rb_csum_q, rb_csum_d;
    logic [ADDR_W:0]   vcnt_q, vcnt_d;
    logic              cpu_clr_q, cpu_clr_d;

    logic              xfer;
    logic              rd_issue;
    logic [ADDR_W:0]   vcnt_last;
    logic [DATA_W-1:0] rb_next;

    function automatic logic [DATA_W-1:0] csum_fold(input logic [DATA_W-1:0] c,
                                                    input logic [DATA_W-1:0] w);
        return {c[DATA_W-2:0], c[DATA_W-1]} ^ w;
    endfunction

    assign xfer      = (state_q == StLoad) && host_valid_i;
    // Verify runs len+2 cycles: reads on 0..len, the last cycle only folds the final read.
    assign vcnt_last = {1'b0, len_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign rd_issue  = (state_q == StVerify) && (vcnt_q <= {1'b0, len_q});
    assign rb_next   = csum_fold(rb_csum_q, mem_rdata_i);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        csum_d    = csum_q;
        rb_csum_d = rb_csum_q;
        vcnt_d    = vcnt_q;
        case (state_q)
            StIdle, StError: begin
                if (start_i) begin
                    state_d = StLoad;
                    len_d   = len_i;
                    addr_d  = '0;
                    csum_d  = '0;
                end
            end
            StLoad: begin
                if (xfer) begin
                    csum_d = csum_fold(csum_q, host_data_i);
                    if (addr_q == len_q) begin
                        state_d   = VERIFY ? StVerify : StRun;
                        vcnt_d    = '0;
                        rb_csum_d = '0;
                    end else begin
                        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            StVerify: begin
                vcnt_d = vcnt_q + {{ADDR_W{1'b0}}, 1'b1};
                if (vcnt_q != '0) begin
                    rb_csum_d = rb_next;
                end
                if (vcnt_q == vcnt_last) begin
                    state_d = (rb_next == csum_q) ? StRun : StError;
                end
            end
            StRun: begin
                if (halt_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered so the core reset only moves on clock edges.
        cpu_clr_d = (state_d != StRun);
    end

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q   <= StIdle;
            len_q     <= '0;
            addr_q    <= '0;
            csum_q    <= '0;
            rb_csum_q <= '0;
            vcnt_q    <= '0;
            cpu_clr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            csum_q    <= csum_d;
            rb_csum_q <= rb_csum_d;
            vcnt_q    <= vcnt_d;
            cpu_clr_q <= cpu_clr_d;
        end
    end

    always_comb begin
        host_ready_o = (state_q == StLoad);
        mem_en_o     = xfer || rd_issue;
        mem_wen_o    = xfer;
        mem_addr_o   = '0;
        if (xfer) begin
            mem_addr_o = addr_q;
        end else if (rd_issue) begin
            mem_addr_o = vcnt_q[ADDR_W-1:0];
        end
        mem_wdata_o  = xfer ? host_data_i : '0;
        busy_o       = (state_q == StLoad) || (state_q == StVerify);
        done_o       = (state_q == StRun);
        error_o      = (state_q == StError);
        load_csum_o  = (state_q == StRun) ? csum_q : '0;
        cpu_clr_o    = cpu_clr_q;
    end

endmodule
